// File: rtl/fft_pkg.sv
// Shared constants for the radix-2 FFT datapath: sequencer state encoding,
// default size/latency parameters, and twiddle format shared with the
// butterfly and twiddle ROM. No logic, no latency, no flow control.
package fft_pkg;

    // Default build configuration
    localparam int FFT_LOG2_N_DEF       = 6;
    localparam int FFT_MEM_LATENCY_DEF  = 1;
    localparam int FFT_BFLY_LATENCY_DEF = 3;

    // Twiddle word format: signed fixed point, Q1.15
    localparam int FFT_TW_WIDTH = 16;
    localparam int FFT_TW_FRAC  = 15;

    // Sequencer states (plain constants so legacy code can compare against them)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly pair / twiddle index generator for one DIT stage.
// Latency: purely combinational. Backpressure: none (pure function of stage, j).
// Ports: stage, j (butterfly index within stage) in; addr_a, addr_b, tw_addr out.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2_N = FFT_LOG2_N_DEF
) (
    input  logic [LOG2_N-1:0] stage,
    input  logic [LOG2_N-2:0] j,
    output logic [LOG2_N-1:0] addr_a,
    output logic [LOG2_N-1:0] addr_b,
    output logic [LOG2_N-2:0] tw_addr
);

    localparam logic [LOG2_N-1:0] STAGE_ONE  = LOG2_N'(1);
    localparam logic [LOG2_N-1:0] STAGE_LAST = LOG2_N'(LOG2_N - 1);
    localparam logic [LOG2_N-2:0] J_ONES     = '1;

    logic [LOG2_N-1:0] j_ext;
    logic [LOG2_N-2:0] k_mask;
    logic [LOG2_N-2:0] k;
    logic [LOG2_N-1:0] group_base;

    always_comb begin
        j_ext      = {1'b0, j};
        // k = j mod h; h-1 never exceeds N/2-1 so the mask fits in the j width
        k_mask     = ~(J_ONES << stage);
        k          = j & k_mask;
        // Start of the butterfly group: group number times 2h
        group_base = (j_ext >> stage) << (stage + STAGE_ONE);
        addr_a     = group_base | {1'b0, k};
        addr_b     = addr_a | (STAGE_ONE << stage);
        tw_addr    = k << (STAGE_LAST - stage);
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT control: issues pair reads + twiddle index, writes
// results back D = MEM_LATENCY + BFLY_LATENCY cycles later, drains between stages.
// Backpressure: none; the butterfly is assumed fixed-latency, write-back runs off
// an internal delay line. Optional build macro LATENCY_CHECK_EN enables err.
// Ports: clk, rst (sync, active-high), start -> busy, done, stage; rd_en,
// rd_addr_a/b, tw_addr, bf_in_valid to RAM/butterfly; bf_out_valid from the
// butterfly; wr_en, wr_addr_a/b to RAM; err sticky latency-mismatch flag.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2_N       = FFT_LOG2_N_DEF,
    parameter int MEM_LATENCY  = FFT_MEM_LATENCY_DEF,
    parameter int BFLY_LATENCY = FFT_BFLY_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [LOG2_N-1:0] stage,
    output logic              rd_en,
    output logic [LOG2_N-1:0] rd_addr_a,
    output logic [LOG2_N-1:0] rd_addr_b,
    output logic [LOG2_N-2:0] tw_addr,
    output logic              bf_in_valid,
    input  logic              bf_out_valid,
    output logic              wr_en,
    output logic [LOG2_N-1:0] wr_addr_a,
    output logic [LOG2_N-1:0] wr_addr_b,
    output logic              err
);

    localparam int D = MEM_LATENCY + BFLY_LATENCY;
    localparam logic [LOG2_N-2:0] J_LAST     = '1;
    localparam logic [LOG2_N-2:0] J_ONE      = (LOG2_N-1)'(1);
    localparam logic [LOG2_N-1:0] STAGE_ONE  = LOG2_N'(1);
    localparam logic [LOG2_N-1:0] STAGE_LAST = LOG2_N'(LOG2_N - 1);

    logic [1:0]        state_q, state_d;
    logic [LOG2_N-1:0] stage_q, stage_d;
    logic [LOG2_N-2:0] j_q, j_d;

    // Delay line: valid plus the pair addresses, one entry per cycle of latency
    logic [D-1:0]      vld_q, vld_d;
    logic [LOG2_N-1:0] pipe_a_q [D];
    logic [LOG2_N-1:0] pipe_a_d [D];
    logic [LOG2_N-1:0] pipe_b_q [D];
    logic [LOG2_N-1:0] pipe_b_d [D];

    logic [LOG2_N-1:0] gen_addr_a;
    logic [LOG2_N-1:0] gen_addr_b;
    logic [LOG2_N-2:0] gen_tw_addr;
    logic              pending;

    fft_addr_gen #(
        .LOG2_N (LOG2_N)
    ) u_addr_gen (
        .stage   (stage_q),
        .j       (j_q),
        .addr_a  (gen_addr_a),
        .addr_b  (gen_addr_b),
        .tw_addr (gen_tw_addr)
    );

    // Addresses are held at zero outside issue cycles so idle outputs stay quiet
    assign rd_en       = (state_q == ST_ISSUE);
    assign rd_addr_a   = rd_en ? gen_addr_a  : '0;
    assign rd_addr_b   = rd_en ? gen_addr_b  : '0;
    assign tw_addr     = rd_en ? gen_tw_addr : '0;
    assign bf_in_valid = vld_q[MEM_LATENCY-1];
    assign wr_en       = vld_q[D-1];
    assign wr_addr_a   = pipe_a_q[D-1];
    assign wr_addr_b   = pipe_b_q[D-1];
    assign busy        = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign stage       = stage_q;

    // Any write still in flight behind the output tap; when none is, the
    // current wr_en is the last write of the stage.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < D - 1; i++) begin
            pending = pending | vld_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        j_d     = j_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    stage_d = '0;
                    j_d     = '0;
                end
            end
            ST_ISSUE: begin
                j_d = j_q + J_ONE;
                if (j_q == J_LAST) begin
                    state_d = ST_DRAIN;
                    j_d     = '0;
                end
            end
            ST_DRAIN: begin
                // Next stage reads only after this stage's last write lands
                if (wr_en && !pending) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = ST_DONE;
                        stage_d = '0;
                    end else begin
                        state_d = ST_ISSUE;
                        stage_d = stage_q + STAGE_ONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        vld_d       = {vld_q[D-2:0], rd_en};
        pipe_a_d[0] = rd_addr_a;
        pipe_b_d[0] = rd_addr_b;
        for (int i = 1; i < D; i++) begin
            pipe_a_d[i] = pipe_a_q[i-1];
            pipe_b_d[i] = pipe_b_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            j_q     <= '0;
            vld_q   <= '0;
            for (int i = 0; i < D; i++) begin
                pipe_a_q[i] <= '0;
                pipe_b_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            j_q     <= j_d;
            vld_q   <= vld_d;
            for (int i = 0; i < D; i++) begin
                pipe_a_q[i] <= pipe_a_d[i];
                pipe_b_q[i] <= pipe_b_d[i];
            end
        end
    end

`ifdef LATENCY_CHECK_EN
    // The butterfly's own valid must line up with our write tap every cycle
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (bf_out_valid ^ vld_q[D-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_bf_out_valid;
    assign unused_bf_out_valid = bf_out_valid;
    assign err = 1'b0;
`endif

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Control engine for an in-place radix-2 DIT FFT over a dual-port sample RAM, driving one pipelined butterfly unit.
- For each stage it issues read addresses for butterfly pairs and the twiddle-ROM index, and strobes the butterfly input-valid.
- It delays the pair addresses to write back butterfly results to the same locations, and drains the pipeline between stages to avoid read-after-write hazards.
- Input samples are already in bit-reversed order in RAM; the datapath (RAM → butterfly → RAM) is wired outside this block.

Parameters:
- LOG2_N, 6, log2 of FFT size N; legal range 2..12.
- MEM_LATENCY, 1, cycles from rd_en to RAM/twiddle-ROM data valid.
- BFLY_LATENCY, 3, cycles from butterfly data_in_valid to data_out_valid.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a full FFT; sampled only in IDLE.
- busy  out  1  high from the first issue cycle through the final write cycle.
- done  out  1  one-cycle pulse the cycle after the final write.
- stage  out  LOG2_N bits wide (ceil(log2 LOG2_N) used)  current stage index, 0..LOG2_N-1.
- rd_en  out  1  RAM read strobe, both ports.
- rd_addr_a  out  LOG2_N  upper-leg read address.
- rd_addr_b  out  LOG2_N  lower-leg read address.
- tw_addr  out  LOG2_N-1  twiddle ROM index, presented with rd_en.
- bf_in_valid  out  1  butterfly data_in_valid; rd_en delayed MEM_LATENCY cycles.
- bf_out_valid  in  1  butterfly data_out_valid.
- wr_en  out  1  RAM write strobe, both ports.
- wr_addr_a  out  LOG2_N  write address for butterfly output_1.
- wr_addr_b  out  LOG2_N  write address for butterfly output_2.
- err  out  1  sticky latency-mismatch flag; constant 0 when the optional feature is compiled out.

Behaviour:
- Reset: all outputs 0, state IDLE, stage 0, butterfly counter j 0, delay lines cleared. Reset mid-run aborts immediately; wr_en is 0 from the next cycle and no done is produced.
- States and transitions:
  - IDLE: on start go to ISSUE at stage 0, j=0. start is ignored in every other state.
  - ISSUE: rd_en=1 every cycle, j counts 0..N/2-1; after j=N/2-1 go to DRAIN.
  - DRAIN: rd_en=0; wait for the stage's last wr_en. In the cycle after it, go to ISSUE with stage+1, or to DONE after stage LOG2_N-1.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Address generation, with h = 1<<stage and k = j & (h-1):
  - rd_addr_a = ((j>>stage) << (stage+1)) | k.
  - rd_addr_b = rd_addr_a | h.
  - tw_addr = k << (LOG2_N-1-stage).
  - Bits shifted beyond the port width are dropped; no arithmetic overflow is possible.
- Pipeline: a delay line of depth D = MEM_LATENCY + BFLY_LATENCY carries {valid, addr_a, addr_b}. wr_en and wr_addr_* are its output; bf_in_valid is the valid tap at MEM_LATENCY.
- Write-back is driven by the internal delay line, not by bf_out_valid. wr_en for issue cycle t occurs at t+D.
- Stage period is N/2 + D cycles. The next stage's first read occurs the cycle after the previous stage's last write, so the RAM needs no write-first/read-first guarantee.
- Total run: start sampled at cycle 0, first rd_en at cycle 1, final wr_en at cycle LOG2_N*(N/2+D) - D + D, done on the following cycle.
- busy falls in the same cycle done rises.

Optional Feature:
- Macro LATENCY_CHECK_EN.
- Defined: each cycle compare bf_out_valid with the delay-line tap at D. Any mismatch sets err, which stays set until rst; sequencing is unaffected.
- Undefined: bf_out_valid is unused and err is tied 0.

Decomposition:
- Shared package fft_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN, DONE}.
  - default LOG2_N, MEM_LATENCY, BFLY_LATENCY constants.
  - twiddle width/fraction constants shared with the butterfly and twiddle ROM.
- One natural sub-module: fft_addr_gen, a pure function of (stage, j) producing rd_addr_a, rd_addr_b and tw_addr.

Test Plan:
- LOG2_N=3, start at cycle 0 → rd_en cycles 1-4 with stage 0 pairs (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0; wr_en cycles 5-8 with the same pairs.
- Same run, stage 1 → rd_en cycles 9-12 with pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2.
- Same run, stage 2 → rd_en cycles 17-20 with pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3; last wr_en cycle 24; done at cycle 25; busy high for cycles 1-24.
- start pulsed at cycles 3 and 10 during a run → ignored; schedule identical to the previous scenario.
- rst asserted at cycle 11 → from cycle 12 all outputs are 0 and state is IDLE, with no done; a new start then reproduces the first scenario exactly.
- LATENCY_CHECK_EN defined, bf_out_valid stimulated one cycle late → err=1 at the first mismatch, held through done, cleared only by rst.
